// File: rtl/bp_pkg.sv
// Shared BTB types: geometry, RAM entry layout, queued update record, port grant.
// No logic, so no latency.
// No flow control.
package bp_pkg;

    localparam int BTB_IDX_W = 4;
    localparam int BTB_TAG_W = 26;

    // Field order matches the RAM word: {valid, tag, target, pred}
    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
        logic                 pred;
    } btb_entry_t;

    typedef struct packed {
        logic [BTB_IDX_W-1:0] idx;
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
        logic                 taken;
        logic                 wrt;
        logic                 wrp;
    } upd_req_t;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_READ,
        GNT_WRITE
    } gnt_t;

endpackage

// File: rtl/upd_fifo.sv
// Two-entry queue of pending BTB updates.
// Head is visible the cycle after push.
// No internal backpressure: the caller pops whenever it pushes while full.
module upd_fifo
    import bp_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  upd_req_t push_dat,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output upd_req_t head
);

    upd_req_t   mem_q [2];
    upd_req_t   mem_d [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       wr_ptr;

    // With two entries a push while full lands in the slot being popped.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr   = rd_ptr_q ^ cnt_q[0];
        if (push) begin
            mem_d[wr_ptr] = push_dat;
        end
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/btb_port_arbiter.sv
// Arbitrates a single-port BTB RAM between fetch lookups and queued branch updates.
// Lookup result one cycle after a READ grant; updates drain with at most 3 cycles of age deferral.
// Fetch is stalled (if_stall) only in cycles where a WRITE takes the port from a valid lookup.
module btb_port_arbiter
    import bp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        if_stall,
    output logic        hp_valid,
    output logic [1:0]  hp,
    output logic [31:0] hp_target,
    input  logic        flush,
    input  logic        upd_wrt,
    input  logic        upd_wrp,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    output logic        ram_en,
    output logic        ram_we,
    output logic [3:0]  ram_addr,
    output logic [1:0]  ram_wmask,
    output logic [59:0] ram_wdata,
    input  logic [59:0] ram_rdata
);

    upd_req_t             upd_req, head;
    logic                 push, pop, fifo_full, fifo_empty;
    gnt_t                 gnt;
    logic [1:0]           age_q, age_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [BTB_TAG_W-1:0] rd_tag_q, rd_tag_d;
    btb_entry_t           rd_ent, wr_ent;
    logic                 hit;
    logic                 unused_pc_bits;

    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

    always_comb begin
        upd_req.idx    = upd_pc[5:2];
        upd_req.tag    = upd_pc[31:6];
        upd_req.target = upd_target;
        upd_req.taken  = upd_taken;
        upd_req.wrt    = upd_wrt;
        upd_req.wrp    = upd_wrp;
        push           = rst_n & (upd_wrt | upd_wrp);
    end

    upd_fifo u_upd_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (upd_req),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

    // A full queue must drain now so that a same-cycle push cannot overflow it.
    always_comb begin
        gnt = GNT_IDLE;
        if (rst_n) begin
            if (!fifo_empty && (fifo_full || !if_valid || age_q == 2'd3)) begin
                gnt = GNT_WRITE;
            end else if (if_valid) begin
                gnt = GNT_READ;
            end
        end
        pop      = (gnt == GNT_WRITE);
        if_stall = if_valid & (gnt == GNT_WRITE);
    end

    always_comb begin
        wr_ent.valid  = 1'b1;
        wr_ent.tag    = head.tag;
        wr_ent.target = head.target;
        wr_ent.pred   = head.taken;
        ram_en        = (gnt != GNT_IDLE);
        ram_we        = (gnt == GNT_WRITE);
        ram_addr      = 4'd0;
        ram_wmask     = 2'b00;
        ram_wdata     = '0;
        if (gnt == GNT_WRITE) begin
            ram_addr  = head.idx;
            ram_wmask = {head.wrt, head.wrp};
            ram_wdata = wr_ent;
        end else if (gnt == GNT_READ) begin
            ram_addr  = if_pc[5:2];
        end
    end

    always_comb begin
        age_d = age_q;
        if (pop || fifo_empty) begin
            age_d = 2'd0;
        end else if (age_q != 2'd3) begin
            age_d = age_q + 2'd1;
        end
        rd_vld_d = (gnt == GNT_READ) & ~flush;
        rd_tag_d = (gnt == GNT_READ) ? if_pc[31:6] : rd_tag_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            age_q    <= 2'd0;
            rd_vld_q <= 1'b0;
            rd_tag_q <= '0;
        end else begin
            age_q    <= age_d;
            rd_vld_q <= rd_vld_d;
            rd_tag_q <= rd_tag_d;
        end
    end

    // RAM data arrives the cycle after the READ grant; a flush then still kills it.
    always_comb begin
        rd_ent    = btb_entry_t'(ram_rdata);
        hp_valid  = rd_vld_q & ~flush;
        hit       = hp_valid & rd_ent.valid & (rd_ent.tag == rd_tag_q);
        hp        = {hit, hit & rd_ent.pred};
        hp_target = hit ? rd_ent.target : 32'd0;
    end

endmodule

// File: tb/tb_btb_port_arbiter.sv
// Directed bench for btb_port_arbiter with a behavioural single-port BTB RAM.
module tb_btb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_stall;
    logic        hp_valid;
    logic [1:0]  hp;
    logic [31:0] hp_target;
    logic        flush;
    logic        upd_wrt, upd_wrp, upd_taken;
    logic [31:0] upd_pc, upd_target;
    logic        ram_en, ram_we;
    logic [3:0]  ram_addr;
    logic [1:0]  ram_wmask;
    logic [59:0] ram_wdata;
    logic [59:0] ram_rdata = '0;
    logic [59:0] ram_mem [16] = '{default: '0};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    btb_port_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_stall   (if_stall),
        .hp_valid   (hp_valid),
        .hp         (hp),
        .hp_target  (hp_target),
        .flush      (flush),
        .upd_wrt    (upd_wrt),
        .upd_wrp    (upd_wrp),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wmask  (ram_wmask),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Single-port RAM: masked write, one-cycle registered read.
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            if (ram_wmask[1]) ram_mem[ram_addr][59:1] <= ram_wdata[59:1];
            if (ram_wmask[0]) ram_mem[ram_addr][0]    <= ram_wdata[0];
        end else if (ram_en) begin
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic wrt, input logic wrp, input logic taken,
                       input logic [31:0] pc, input logic [31:0] tgt);
        upd_wrt    = wrt;
        upd_wrp    = wrp;
        upd_taken  = taken;
        upd_pc     = pc;
        upd_target = tgt;
    endtask

    task automatic no_upd();
        upd(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Assumes the update queue is empty so the lookup is granted immediately.
    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic [1:0] exp_hp, input logic [31:0] exp_tgt);
        next_cyc();
        if_valid = 1'b1;
        if_pc    = pc;
        next_cyc();
        if_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_vld"}, 64'(hp_valid), 64'd1);
        chk({tag, "_hp"},  64'(hp), 64'(exp_hp));
        chk({tag, "_tgt"}, 64'(hp_target), 64'(exp_tgt));
    endtask

    logic [59:0] exp_w;

    initial begin
        // Reset with a live lookup and update presented: both must be ignored.
        rst_n    = 1'b0;
        if_valid = 1'b1;
        if_pc    = 32'h40;
        flush    = 1'b0;
        upd(1'b1, 1'b1, 1'b1, 32'h40, 32'h999);
        next_cyc();
        @(negedge clk);
        chk("rst_ram_en",   64'(ram_en), 64'd0);
        chk("rst_ram_we",   64'(ram_we), 64'd0);
        chk("rst_stall",    64'(if_stall), 64'd0);
        chk("rst_hp_valid", 64'(hp_valid), 64'd0);
        chk("rst_hp",       64'(hp), 64'd0);
        chk("rst_hp_tgt",   64'(hp_target), 64'd0);
        next_cyc();
        rst_n    = 1'b1;
        if_valid = 1'b0;
        no_upd();
        @(negedge clk);
        chk("post_rst_idle", 64'(ram_en), 64'd0);

        // Write 0x40 -> 0x100 with port free, then read it back.
        next_cyc();
        upd(1'b1, 1'b1, 1'b1, 32'h40, 32'h100);
        @(negedge clk);
        chk("w1_push_idle", 64'(ram_en), 64'd0);
        next_cyc();
        no_upd();
        exp_w = {1'b1, 26'd1, 32'h100, 1'b1};
        @(negedge clk);
        chk("w1_we",    64'(ram_we), 64'd1);
        chk("w1_addr",  64'(ram_addr), 64'd0);
        chk("w1_mask",  64'(ram_wmask), 64'd3);
        chk("w1_wdata", 64'(ram_wdata), 64'(exp_w));
        next_cyc();
        if_valid = 1'b1;
        if_pc    = 32'h40;
        @(negedge clk);
        chk("r1_en",    64'(ram_en), 64'd1);
        chk("r1_we",    64'(ram_we), 64'd0);
        chk("r1_stall", 64'(if_stall), 64'd0);
        next_cyc();
        if_valid = 1'b0;
        @(negedge clk);
        chk("r1_vld", 64'(hp_valid), 64'd1);
        chk("r1_hp",  64'(hp), 64'd3);
        chk("r1_tgt", 64'(hp_target), 64'h100);

        // Same index, different tag.
        lookup("alias", 32'h1040, 2'b00, 32'd0);

        // Flush the cycle after a READ grant, then flush during the grant cycle.
        next_cyc();
        if_valid = 1'b1;
        if_pc    = 32'h40;
        next_cyc();
        if_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        chk("fl1_vld", 64'(hp_valid), 64'd0);
        chk("fl1_hp",  64'(hp), 64'd0);
        chk("fl1_tgt", 64'(hp_target), 64'd0);
        next_cyc();
        if_valid = 1'b1;
        flush    = 1'b1;
        next_cyc();
        if_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        chk("fl0_vld", 64'(hp_valid), 64'd0);
        chk("fl0_hp",  64'(hp), 64'd0);

        // Age-forced write under continuous fetch: READ x3 then WRITE with stall.
        next_cyc();
        if_valid = 1'b1;
        if_pc    = 32'h40;
        upd(1'b1, 1'b1, 1'b0, 32'h84, 32'h200);
        @(negedge clk);
        chk("age_c0_stall", 64'(if_stall), 64'd0);
        chk("age_c0_we",    64'(ram_we), 64'd0);
        next_cyc();
        no_upd();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("age_c%0d_stall", k), 64'(if_stall), (k == 4) ? 64'd1 : 64'd0);
            chk($sformatf("age_c%0d_we", k),    64'(ram_we),   (k == 4) ? 64'd1 : 64'd0);
            chk($sformatf("age_c%0d_hp", k),    64'(hp), 64'd3);
            if (k == 4) begin
                chk("age_addr", 64'(ram_addr), 64'd1);
                chk("age_mask", 64'(ram_wmask), 64'd3);
            end
            next_cyc();
        end
        @(negedge clk);
        chk("age_c5_stall", 64'(if_stall), 64'd0);
        chk("age_c5_vld",   64'(hp_valid), 64'd0);
        if_valid = 1'b0;
        lookup("age_rd", 32'h84, 2'b10, 32'h200);

        // Three back-to-back pushes under fetch: full queue forces two writes.
        next_cyc();
        if_valid = 1'b1;
        if_pc    = 32'h40;
        upd(1'b1, 1'b0, 1'b1, 32'h88, 32'h300);
        @(negedge clk);
        chk("ff_q0_stall", 64'(if_stall), 64'd0);
        next_cyc();
        upd(1'b0, 1'b1, 1'b1, 32'h8C, 32'h304);
        @(negedge clk);
        chk("ff_q1_stall", 64'(if_stall), 64'd0);
        chk("ff_q1_we",    64'(ram_we), 64'd0);
        next_cyc();
        upd(1'b1, 1'b1, 1'b1, 32'h90, 32'h308);
        @(negedge clk);
        chk("ff_q2_stall", 64'(if_stall), 64'd1);
        chk("ff_q2_addr",  64'(ram_addr), 64'd2);
        chk("ff_q2_mask",  64'(ram_wmask), 64'd2);
        next_cyc();
        no_upd();
        @(negedge clk);
        chk("ff_q3_stall", 64'(if_stall), 64'd1);
        chk("ff_q3_addr",  64'(ram_addr), 64'd3);
        chk("ff_q3_mask",  64'(ram_wmask), 64'd1);
        next_cyc();
        @(negedge clk);
        chk("ff_q4_stall", 64'(if_stall), 64'd0);
        chk("ff_q4_we",    64'(ram_we), 64'd0);
        next_cyc();
        if_valid = 1'b0;
        @(negedge clk);
        chk("ff_q5_we",   64'(ram_we), 64'd1);
        chk("ff_q5_addr", 64'(ram_addr), 64'd4);
        chk("ff_q5_mask", 64'(ram_wmask), 64'd3);
        next_cyc();
        @(negedge clk);
        chk("ff_q6_en", 64'(ram_en), 64'd0);
        lookup("ff_rd88", 32'h88, 2'b10, 32'h300);
        lookup("ff_rd8c", 32'h8C, 2'b00, 32'd0);
        lookup("ff_rd90", 32'h90, 2'b11, 32'h308);

        // Reset with two updates queued: they must never reach the RAM.
        next_cyc();
        if_valid = 1'b1;
        if_pc    = 32'h40;
        upd(1'b1, 1'b1, 1'b1, 32'hA0, 32'h400);
        next_cyc();
        upd(1'b1, 1'b1, 1'b1, 32'hA4, 32'h404);
        @(negedge clk);
        chk("rq_r1_stall", 64'(if_stall), 64'd0);
        next_cyc();
        rst_n = 1'b0;
        no_upd();
        @(negedge clk);
        chk("rq_r2_en", 64'(ram_en), 64'd0);
        chk("rq_r2_we", 64'(ram_we), 64'd0);
        next_cyc();
        rst_n    = 1'b1;
        if_valid = 1'b0;
        for (int k = 3; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("rq_r%0d_en", k),  64'(ram_en), 64'd0);
            chk($sformatf("rq_r%0d_we", k),  64'(ram_we), 64'd0);
            chk($sformatf("rq_r%0d_vld", k), 64'(hp_valid), 64'd0);
            next_cyc();
        end
        lookup("rq_rdA0", 32'hA0, 2'b00, 32'd0);
        lookup("rq_rdA4", 32'hA4, 2'b00, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
